// File: rtl/dat_mem_arb_pkg.sv
// dat_mem_arb_pkg
//   Shared types for the dat_mem arbiter: the access-sequencer state
//   encoding and the requester index constants.
package dat_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dat_mem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin picker.
//   Ports:
//     valid0, valid1 : request lines
//     last           : index of the requester granted most recently
//     grant          : index of the winner (meaningful when any_valid)
//     any_valid      : at least one request present
module rr_pick2
  import dat_mem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant,
  output logic any_valid
);

  always_comb begin
    grant = REQ0;
    if (valid0 && valid1) begin
      // tie: the requester not granted last time wins
      grant = (last == REQ0) ? REQ1 : REQ0;
    end else if (valid1) begin
      grant = REQ1;
    end
  end

  assign any_valid = valid0 | valid1;

endmodule

// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter
//   Round-robin arbiter and three-state access sequencer between two
//   masters (core load/store unit, DMA/boot loader) and the single-port
//   dat_mem.
//
//   state  | meaning
//   IDLE   | sample valids, latch winner's request
//   ACCESS | drive latched request to dat_mem, capture read data
//   RESP   | one-cycle ack to winner, valids ignored
//
//   Ports:
//     clk, reset                : clock, async active-high reset
//     reqN_valid/we/addr/wdata  : request from requester N (held until ack)
//     reqN_ack                  : one-cycle completion pulse
//     reqN_rdata                : last read result for requester N
//     mem_addr/mem_dat_in       : latched address/data to dat_mem
//     mem_wr_en                 : write strobe, high only in ACCESS on writes
//     mem_dat_out               : combinational read data from dat_mem
//     busy                      : sequencer not idle
module dat_mem_arbiter
  import dat_mem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ack,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ack,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_dat_out,
  output logic          busy
);

  arb_state_t    state;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_idx;
  logic          last;
  logic          grant;
  logic          any_valid;

  rr_pick2 u_pick (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (last),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_idx    <= REQ0;
      last       <= REQ1;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            lat_idx <= grant;
            last    <= grant;
            if (grant == REQ1) begin
              lat_we    <= req1_we;
              lat_addr  <= req1_addr;
              lat_wdata <= req1_wdata;
            end else begin
              lat_we    <= req0_we;
              lat_addr  <= req0_addr;
              lat_wdata <= req0_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // ack is raised here so it is a registered pulse during RESP
          if (lat_idx == REQ1) begin
            req1_ack <= 1'b1;
            if (!lat_we) req1_rdata <= mem_dat_out;
          end else begin
            req0_ack <= 1'b1;
            if (!lat_we) req0_rdata <= mem_dat_out;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Address/data stay on the latched values outside ACCESS; only the
  // strobe is gated, and it depends on registers alone.
  assign mem_addr   = lat_addr;
  assign mem_dat_in = lat_wdata;
  assign mem_wr_en  = (state == ACCESS) && lat_we;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dat_mem_arbiter.sv
module tb_dat_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_in;
  logic          mem_wr_en;
  logic [DW-1:0] mem_dat_out;
  logic          busy;

  always #5 clk = ~clk;

  dat_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req_valid[0]),
    .req0_we     (req_we[0]),
    .req0_addr   (req_addr[0]),
    .req0_wdata  (req_wdata[0]),
    .req0_ack    (ack0),
    .req0_rdata  (rdata0),
    .req1_valid  (req_valid[1]),
    .req1_we     (req_we[1]),
    .req1_addr   (req_addr[1]),
    .req1_wdata  (req_wdata[1]),
    .req1_ack    (ack1),
    .req1_rdata  (rdata1),
    .mem_addr    (mem_addr),
    .mem_dat_in  (mem_dat_in),
    .mem_wr_en   (mem_wr_en),
    .mem_dat_out (mem_dat_out),
    .busy        (busy)
  );

  // dat_mem stand-in: synchronous write, combinational read
  logic [DW-1:0] mem [256];
  logic          init_done;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 60) ? 8'd30 : 8'(i ^ 'h5A);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_dat_in;
    end
  end
  assign mem_dat_out = mem[mem_addr];

  // reference model
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_rdata [2];
  int            ref_last;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  // Called in an IDLE cycle with requests already driven; leaves the bench
  // in the RESP cycle.
  task automatic txn(input string tag, input bit perturb, output int won);
    int            w;
    logic          twe;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    if (req_valid[0] && req_valid[1]) w = 1 - ref_last;
    else if (req_valid[1])            w = 1;
    else                              w = 0;
    twe = req_we[w];
    ta  = req_addr[w];
    td  = req_wdata[w];
    tick();
    chk({tag, ".acc_busy"}, busy, 1);
    chk({tag, ".acc_addr"}, mem_addr, ta);
    chk({tag, ".acc_din"}, mem_dat_in, td);
    chk({tag, ".acc_wren"}, mem_wr_en, twe);
    chk({tag, ".acc_acks"}, {ack1, ack0}, 0);
    if (perturb) begin
      req_addr[w]  = ~ta;
      req_wdata[w] = ~td;
      req_we[w]    = ~twe;
      #1;
      chk({tag, ".hold_addr"}, mem_addr, ta);
      chk({tag, ".hold_din"}, mem_dat_in, td);
      chk({tag, ".hold_wren"}, mem_wr_en, twe);
    end
    tick();
    if (twe) ref_mem[ta] = td;
    else     ref_rdata[w] = ref_mem[ta];
    ref_last = w;
    chk({tag, ".resp_acks"}, {ack1, ack0}, (w == 1) ? 2'b10 : 2'b01);
    chk({tag, ".resp_wren"}, mem_wr_en, 0);
    chk({tag, ".resp_addr"}, mem_addr, ta);
    chk({tag, ".rdata0"}, rdata0, ref_rdata[0]);
    chk({tag, ".rdata1"}, rdata1, ref_rdata[1]);
    won = w;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_wren"}, mem_wr_en, 0);
    chk({tag, ".idle_acks"}, {ack1, ack0}, 0);
  endtask

  initial begin
    int won;
    reset     = 1'b1;
    init_done = 1'b0;
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_last = 1;
    repeat (3) tick();
    init_done = 1'b1;

    // reset state
    chk("rst0.busy", busy, 0);
    chk("rst0.outs", {mem_wr_en, mem_addr, mem_dat_in, ack0, ack1, rdata0, rdata1}, 0);
    reset = 1'b0;
    tick();

    // single read: req0 reads address 60
    set_req(0, 1'b1, 1'b0, 8'd60, 8'h00);
    txn("rd60", 1'b0, won);
    chk("rd60.value", rdata0, 8'd30);
    req_valid[0] = 1'b0;
    tick();
    idle_check("rd60");

    // req1 write then read at the top address
    set_req(1, 1'b1, 1'b1, 8'hFF, 8'h5C);
    txn("wrff", 1'b0, won);
    req_valid[1] = 1'b0;
    tick();
    idle_check("wrff");
    chk("wrff.mem", mem[255], 8'h5C);
    set_req(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    txn("rdff", 1'b0, won);
    chk("rdff.value", rdata1, 8'h5C);
    req_valid[1] = 1'b0;
    tick();

    // reset asserted mid-ACCESS of a write of 0xAA to address 5
    set_req(0, 1'b1, 1'b1, 8'd5, 8'hAA);
    tick();
    chk("rstw.acc_wren", mem_wr_en, 1);
    reset = 1'b1;
    #1;
    chk("rstw.wren", mem_wr_en, 0);
    chk("rstw.busy", busy, 0);
    chk("rstw.outs", {mem_addr, mem_dat_in, ack0, ack1, rdata0, rdata1}, 0);
    req_valid[0] = 1'b0;
    tick();
    chk("rstw.mem5", mem[5], ref_mem[5]);
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    ref_last = 1;
    reset = 1'b0;
    tick();

    // contention right after reset, then sustained fairness (8 grants)
    for (int g = 0; g < 8; g++) begin
      set_req(0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
      set_req(1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
      txn("fair", 1'b0, won);
      chk("fair.order", {ack1, ack0}, (g % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      chk("fair.idle_busy", busy, 0);
    end
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    tick();

    // input hold-off: req0 changes its inputs during ACCESS
    set_req(0, 1'b1, 1'b1, 8'd10, 8'h11);
    txn("hold_wr", 1'b1, won);
    req_valid[0] = 1'b0;
    tick();
    chk("hold_wr.mem10", mem[10], 8'h11);
    chk("hold_wr.mem245", mem[245], ref_mem[245]);
    set_req(1, 1'b1, 1'b0, 8'd10, 8'h00);
    txn("hold_rd1", 1'b0, won);
    chk("hold_rd1.value", rdata1, 8'h11);
    req_valid[1] = 1'b0;
    tick();
    set_req(0, 1'b1, 1'b0, 8'd60, 8'h00);
    txn("hold_rd0", 1'b1, won);
    req_valid[0] = 1'b0;
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                8'($urandom));
      if (!req_valid[0] && !req_valid[1]) begin
        tick();
        idle_check("rnd_none");
      end else begin
        txn("rnd", 1'($urandom_range(0, 1)), won);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        tick();
        idle_check("rnd");
      end
    end

    for (int i = 0; i < 8; i++) chk("final.mem", mem[i], ref_mem[i]);
    chk("final.memff", mem[255], ref_mem[255]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
